data_packet_buffer: RTL and testbench

DATA_PACKET_BUFFER -- requirements
Module: data_packet_buffer

---
 rtl/data_packet_buffer.sv | 92 +++++++++
 tb/tb_data_packet_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_packet_buffer.sv
// Collects a frame of up to DEPTH words into a packed buffer and holds it until acknowledged.
// Optional sticky overflow flag for words offered while a frame is held: define DATA_BUFFER_OVERFLOW_EN.
module data_packet_buffer #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   data_start,
    input  logic                   data_valid,
    input  logic [WIDTH-1:0]       data,
    input  logic                   buffer_ack,
    output logic                   data_ready,
    output logic [WIDTH*DEPTH-1:0] buffer,
    output logic                   buffer_valid,
    output logic [CW-1:0]          count,
    output logic                   overflow
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } state_t;

    state_t state, state_nxt;
    logic   accept;

    assign accept = (state == FILL) && data_valid && data_start;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: next state defaults to the current state first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (data_start) state_nxt = FILL;
            FILL: begin
                if (!data_start)
                    state_nxt = (count != '0) ? HOLD : IDLE;
                else if (data_valid && count == CW'(DEPTH - 1))
                    state_nxt = HOLD;
            end
            HOLD: if (buffer_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are flops loaded from the next state, so they track the state with no input-to-output path.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_ready   <= 1'b0;
            buffer_valid <= 1'b0;
        end else begin
            data_ready   <= (state_nxt == FILL);
            buffer_valid <= (state_nxt == HOLD);
        end
    end

    // NOTE: the frame storage is reset because a reset must visibly clear the buffer output at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buffer <= '0;
            count  <= '0;
        end else if (state == IDLE && data_start) begin
            buffer <= '0;
            count  <= '0;
        end else if (accept) begin
            for (int i = 0; i < DEPTH; i++)
                if (count == CW'(i)) buffer[i*WIDTH +: WIDTH] <= data;
            count <= count + 1'b1;
        end else if (state == HOLD && buffer_ack) begin
            // Contents stay readable after the ack; they are wiped on the next FILL entry.
            count <= '0;
        end
    end

`ifdef DATA_BUFFER_OVERFLOW_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                         overflow <= 1'b0;
        else if (state == HOLD && data_valid) overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_data_packet_buffer.sv
// Scoreboard bench for data_packet_buffer: frames are modelled as word lists, expected
// buffer images are queued at issue time and checked by a monitor when buffer_valid rises.
module tb_data_packet_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int BW    = WIDTH * DEPTH;

`ifdef DATA_BUFFER_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset_n;
    logic             data_start;
    logic             data_valid;
    logic [WIDTH-1:0] data;
    logic             buffer_ack;
    logic             data_ready;
    logic [BW-1:0]    buffer;
    logic             buffer_valid;
    logic [CW-1:0]    count;
    logic             overflow;

    data_packet_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .data_start  (data_start),
        .data_valid  (data_valid),
        .data        (data),
        .buffer_ack  (buffer_ack),
        .data_ready  (data_ready),
        .buffer      (buffer),
        .buffer_valid(buffer_valid),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [BW-1:0] img;
        logic [CW-1:0] cnt;
    } frame_t;

    frame_t           sb[$];
    logic [WIDTH-1:0] stim_q[$];
    logic [BW-1:0]    exp_buf;
    int               exp_cnt;
    bit               exp_ovf;
    int               tests = 0;
    int               fails = 0;
    int               pat[5] = '{1, 0, 1, 1, 0};

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every rising buffer_valid must match the oldest queued frame.
    logic bv_prev = 1'b0;
    always @(negedge clock) begin
        if (buffer_valid && !bv_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_frame", BW'(1), BW'(0));
            end else begin
                frame_t f;
                f = sb.pop_front();
                check("sb_buffer", buffer, f.img);
                check("sb_count", BW'(count), BW'(f.cnt));
                check("sb_ready_low", BW'(data_ready), BW'(0));
            end
        end
        bv_prev <= buffer_valid;
    end

    task automatic run_frame(input int mode);
        int            n;
        int            idx;
        int            p;
        int            guard;
        bit            v;
        logic [BW-1:0] e;
        n = stim_q.size();
        idx = 0; p = 0; guard = 0; e = '0;
        for (int i = 0; i < n; i++) e[i*WIDTH +: WIDTH] = stim_q[i];
        exp_buf = e;
        exp_cnt = n;
        sb.push_back('{e, CW'(n)});

        data_start = 1'b1; data_valid = 1'b0;
        tick();
        check("fill_entry_ready", BW'(data_ready), BW'(1));
        check("fill_entry_clear", buffer, '0);
        check("fill_entry_count", BW'(count), BW'(0));

        while (idx < n && guard < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = pat[p % 5] != 0;
                default: v = ($urandom_range(99) >= 30);
            endcase
            p++; guard++;
            data_valid = v;
            data       = v ? stim_q[idx] : WIDTH'($urandom);
            buffer_ack = 1'($urandom_range(1));
            if (v) idx++;
            tick();
        end
        if (idx < n) check("fill_budget", BW'(idx), BW'(n));
        data_valid = 1'b0; buffer_ack = 1'b0; data_start = 1'b0;
        if (n < DEPTH) tick();
    endtask

    task automatic hold_and_ack(input int cycles, input bit inject);
        for (int k = 0; k < cycles; k++) begin
            tick();
            check("hold_buffer", buffer, exp_buf);
            check("hold_count", BW'(count), BW'(exp_cnt));
            check("hold_valid", BW'(buffer_valid), BW'(1));
            check("hold_ready", BW'(data_ready), BW'(0));
        end
        if (inject) begin
            data_valid = 1'b1; data = WIDTH'($urandom);
            tick();
            data_valid = 1'b0;
            if (OVF_EN) exp_ovf = 1'b1;
            check("ovf_flag", BW'(overflow), BW'(exp_ovf));
            check("ovf_buffer", buffer, exp_buf);
            check("ovf_count", BW'(count), BW'(exp_cnt));
        end
        buffer_ack = 1'b1;
        tick();
        buffer_ack = 1'b0;
        check("ack_valid", BW'(buffer_valid), BW'(0));
        check("ack_count", BW'(count), BW'(0));
        check("ack_ready", BW'(data_ready), BW'(0));
        check("ack_keep_buffer", buffer, exp_buf);
        check("ack_ovf", BW'(overflow), BW'(exp_ovf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_ovf = 1'b0;
        reset_n = 1'b0; data_start = 1'b0; data_valid = 1'b0; data = '0; buffer_ack = 1'b0;
        #12;
        check("rst_buffer", buffer, '0);
        check("rst_count", BW'(count), BW'(0));
        check("rst_valid", BW'(buffer_valid), BW'(0));
        check("rst_ready", BW'(data_ready), BW'(0));
        check("rst_ovf", BW'(overflow), BW'(0));
        @(negedge clock); reset_n = 1'b1;
        tick();

        // Inputs other than data_start are ignored in IDLE.
        data_valid = 1'b1; buffer_ack = 1'b1; data = 16'hBEEF;
        repeat (3) tick();
        data_valid = 1'b0; buffer_ack = 1'b0;
        check("idle_count", BW'(count), BW'(0));
        check("idle_buffer", buffer, '0);
        check("idle_ready", BW'(data_ready), BW'(0));
        check("idle_valid", BW'(buffer_valid), BW'(0));

        // Full frame 0..7, then a 5-cycle hold before the ack.
        stim_q.delete();
        for (int i = 0; i < DEPTH; i++) stim_q.push_back(WIDTH'(i));
        run_frame(0);
        check("full_valid_next", BW'(buffer_valid), BW'(1));
        hold_and_ack(5, 1'b0);

        // Gapped valid pattern packs words contiguously.
        stim_q.delete();
        for (int i = 1; i <= 6; i++) stim_q.push_back(WIDTH'(i * 'h11));
        run_frame(1);
        hold_and_ack(2, 1'b0);

        // Partial frame, plus a word offered during HOLD.
        stim_q = '{16'hA, 16'hB, 16'hC};
        run_frame(0);
        hold_and_ack(3, 1'b1);

        for (int f = 0; f < 20; f++) begin
            int n;
            n = $urandom_range(DEPTH, 1);
            stim_q.delete();
            for (int i = 0; i < n; i++) stim_q.push_back(WIDTH'($urandom));
            run_frame(int'($urandom_range(2)));
            hold_and_ack(int'($urandom_range(4)), 1'($urandom_range(1)));
        end

        // Reset between edges after 4 accepts clears everything without a clock edge.
        data_start = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            data_valid = 1'b1; data = WIDTH'($urandom | 1);
            tick();
        end
        data_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        exp_ovf = 1'b0;
        check("async_rst_buffer", buffer, '0);
        check("async_rst_count", BW'(count), BW'(0));
        check("async_rst_ready", BW'(data_ready), BW'(0));
        check("async_rst_valid", BW'(buffer_valid), BW'(0));
        check("async_rst_ovf", BW'(overflow), BW'(0));
        data_start = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        tick();
        check("post_rst_idle", BW'(data_ready), BW'(0));

        stim_q = '{16'h1234, 16'h5678};
        run_frame(2);
        hold_and_ack(1, 1'b0);

        repeat (2) tick();
        check("sb_drained", BW'(sb.size()), BW'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
